// File: rtl/imgproc_droplet_counter.sv
// -----------------------------------------------------------------------------
// imgproc_droplet_counter
// Streams one frame of packed pixel blocks out of the frame and background
// buffers, writes a per-pixel foreground mask to the mask buffer, and counts
// droplets seen in a detection window of blocks as good or bad.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle frame start pulse, honoured only in IDLE
//   clr_cnt            synchronous clear of both counters and droplet history
//   busy, frame_done   frame in progress / one-cycle end-of-frame pulse
//   rd_addr            block address to the frame and background buffers
//   rd_pixel, bg_pixel frame / background block, RD_LAT cycles after rd_addr
//   wr_en, wr_addr,    mask block write port
//   wr_data
//   good_cnt, bad_cnt  saturating droplet counts
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | rd_addr held at 0, waiting for start
// SCAN  | one block address issued per cycle, 0 .. NUM_BLOCKS-1
// DRAIN | waiting for the read-latency pipeline to empty
// DONE  | single cycle, frame_done high, counters hold the frame result
// -----------------------------------------------------------------------------
module imgproc_droplet_counter #(
   parameter int              PPB        = 16,
   parameter int              PW         = 8,
   parameter int              NUM_BLOCKS = 4800,
   parameter int              ADDR_W     = 13,
   parameter int              RD_LAT     = 2,
   parameter int              DIFF_TH    = 5,
   parameter int              WIN_START  = 1509,
   parameter int              WIN_END    = 1511,
   parameter logic [PW-1:0]   GOOD_CODE  = PW'('h51),
   parameter logic [PW-1:0]   BAD_CODE   = PW'('h64),
   parameter int              CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                clr_cnt,
   output logic                busy,
   output logic                frame_done,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [PPB*PW-1:0]   rd_pixel,
   input  logic [PPB*PW-1:0]   bg_pixel,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [PPB*PW-1:0]   wr_data,
   output logic [CNT_W-1:0]    good_cnt,
   output logic [CNT_W-1:0]    bad_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LP_LAST   = ADDR_W'(NUM_BLOCKS - 1);
   localparam logic [ADDR_W-1:0] LP_WIN_LO = ADDR_W'(WIN_START);
   localparam logic [ADDR_W-1:0] LP_WIN_HI = ADDR_W'(WIN_END);
   localparam logic [PW:0]       LP_TH     = (PW+1)'(DIFF_TH);

   logic [1:0]          r_state;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [RD_LAT-1:0]   r_vld;
   logic [ADDR_W-1:0]   r_adr_pipe [RD_LAT];
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [PPB*PW-1:0]   r_wr_data;
   logic                r_seen_bad;
   logic                r_seen_good;
   logic                r_prev_present;
   logic [CNT_W-1:0]    r_good_cnt;
   logic [CNT_W-1:0]    r_bad_cnt;

   logic                w_smp_vld;
   logic [ADDR_W-1:0]   w_smp_addr;
   logic                w_in_win;
   logic                w_done_entry;
   logic                w_present;
   logic [PPB*PW-1:0]   w_mask;
   logic                w_any_bad;
   logic                w_any_good;
   logic [PW:0]         w_pix;
   logic [PW:0]         w_bg;
   logic [PW:0]         w_diff;

   // Data returning from the buffers belongs to the address at the tail of
   // the delay line, not to the address currently on rd_addr.
   assign w_smp_vld    = r_vld[RD_LAT-1];
   assign w_smp_addr   = r_adr_pipe[RD_LAT-1];
   assign w_in_win     = (w_smp_addr >= LP_WIN_LO) && (w_smp_addr <= LP_WIN_HI);
   assign w_done_entry = (r_state == S_DRAIN) && (r_vld == '0);
   assign w_present    = r_seen_bad | r_seen_good;

   always_comb begin
      w_mask     = '0;
      w_any_bad  = 1'b0;
      w_any_good = 1'b0;
      w_pix      = '0;
      w_bg       = '0;
      w_diff     = '0;
      for (int i = 0; i < PPB; i++) begin
         w_pix  = {1'b0, rd_pixel[i*PW +: PW]};
         w_bg   = {1'b0, bg_pixel[i*PW +: PW]};
         w_diff = (w_pix >= w_bg) ? (w_pix - w_bg) : (w_bg - w_pix);
         if (w_diff > LP_TH)
            w_mask[i*PW +: PW] = '1;
         if (rd_pixel[i*PW +: PW] == BAD_CODE)
            w_any_bad = 1'b1;
         if (rd_pixel[i*PW +: PW] == GOOD_CODE)
            w_any_good = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rd_addr <= '0;
               if (start)
                  r_state <= S_SCAN;
            end
            S_SCAN: begin
               if (r_rd_addr == LP_LAST) begin
                  r_state   <= S_DRAIN;
                  r_rd_addr <= '0;
               end else begin
                  r_rd_addr <= r_rd_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_vld == '0)
                  r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int j = 0; j < RD_LAT; j++)
            r_adr_pipe[j] <= '0;
      end else begin
         r_vld[0]      <= (r_state == S_SCAN);
         r_adr_pipe[0] <= r_rd_addr;
         for (int j = 1; j < RD_LAT; j++) begin
            r_vld[j]      <= r_vld[j-1];
            r_adr_pipe[j] <= r_adr_pipe[j-1];
         end
      end
   end

   // Address and data only move on a real write so the port stays quiet
   // between frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_smp_vld;
         if (w_smp_vld) begin
            r_wr_addr <= w_smp_addr;
            r_wr_data <= w_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen_bad  <= 1'b0;
         r_seen_good <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_seen_bad  <= 1'b0;
         r_seen_good <= 1'b0;
      end else if (w_smp_vld && w_in_win) begin
         if (w_any_bad)
            r_seen_bad <= 1'b1;
         else if (w_any_good)
            r_seen_good <= 1'b1;
      end
   end

   // A droplet visible over several consecutive frames is counted only on
   // its first frame; prev_present remembers the previous frame's verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_good_cnt     <= '0;
         r_bad_cnt      <= '0;
         r_prev_present <= 1'b0;
      end else if (clr_cnt) begin
         r_good_cnt     <= '0;
         r_bad_cnt      <= '0;
         r_prev_present <= 1'b0;
      end else if (w_done_entry) begin
         if (w_present && !r_prev_present) begin
            if (r_seen_bad) begin
               if (r_bad_cnt != '1)
                  r_bad_cnt <= r_bad_cnt + 1'b1;
            end else if (r_good_cnt != '1) begin
               r_good_cnt <= r_good_cnt + 1'b1;
            end
         end
         r_prev_present <= w_present;
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign frame_done = (r_state == S_DONE);
   assign rd_addr    = r_rd_addr;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign good_cnt   = r_good_cnt;
   assign bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_imgproc_droplet_counter.sv
// -----------------------------------------------------------------------------
// tb_imgproc_droplet_counter
// Directed bench for imgproc_droplet_counter with an 8-block frame, window
// blocks 3..4, read latency 2 and 4 pixels per block. Two instances share the
// stimulus: a 16-bit counter instance and a 2-bit one for saturation.
// -----------------------------------------------------------------------------
module tb_imgproc_droplet_counter;

   localparam int PPB = 4;
   localparam int PW  = 8;
   localparam int NB  = 8;
   localparam int AW  = 3;
   localparam int DW  = PPB*PW;
   localparam logic [7:0] GOOD = 8'h51;
   localparam logic [7:0] BAD  = 8'h64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          clr_cnt = 1'b0;
   logic [DW-1:0] rd_pixel = '0;
   logic [DW-1:0] bg_pixel = '0;
   logic [DW-1:0] p_frm1 = '0;
   logic [DW-1:0] p_bg1 = '0;

   logic          busy, frame_done, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data;
   logic [15:0]   good_cnt, bad_cnt;

   logic          s_busy, s_frame_done, s_wr_en;
   logic [AW-1:0] s_rd_addr, s_wr_addr;
   logic [DW-1:0] s_wr_data;
   logic [1:0]    s_good_cnt, s_bad_cnt;

   logic [DW-1:0] frm     [NB];
   logic [DW-1:0] bgm     [NB];
   logic [DW-1:0] exp_msk [NB];
   logic [DW-1:0] msk     [NB];

   int n_vec = 0;
   int n_err = 0;

   imgproc_droplet_counter #(
      .PPB(PPB), .PW(PW), .NUM_BLOCKS(NB), .ADDR_W(AW), .RD_LAT(2),
      .DIFF_TH(5), .WIN_START(3), .WIN_END(4), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr_cnt(clr_cnt),
      .busy(busy), .frame_done(frame_done), .rd_addr(rd_addr),
      .rd_pixel(rd_pixel), .bg_pixel(bg_pixel), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .good_cnt(good_cnt),
      .bad_cnt(bad_cnt)
   );

   imgproc_droplet_counter #(
      .PPB(PPB), .PW(PW), .NUM_BLOCKS(NB), .ADDR_W(AW), .RD_LAT(2),
      .DIFF_TH(5), .WIN_START(3), .WIN_END(4), .CNT_W(2)
   ) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .clr_cnt(clr_cnt),
      .busy(s_busy), .frame_done(s_frame_done), .rd_addr(s_rd_addr),
      .rd_pixel(rd_pixel), .bg_pixel(bg_pixel), .wr_en(s_wr_en),
      .wr_addr(s_wr_addr), .wr_data(s_wr_data), .good_cnt(s_good_cnt),
      .bad_cnt(s_bad_cnt)
   );

   always #5 clk = ~clk;

   // Two-cycle buffer model: address in cycle k, data visible in cycle k+2.
   always @(posedge clk) begin
      p_frm1   <= frm[rd_addr];
      p_bg1    <= bgm[rd_addr];
      rd_pixel <= p_frm1;
      bg_pixel <= p_bg1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_mem();
      for (int b = 0; b < NB; b++) begin
         frm[b]     = '0;
         bgm[b]     = '0;
         exp_msk[b] = '0;
      end
   endtask

   // Code pixels go into both buffers so they never show up in the mask.
   task automatic put_px(input int blk, input int pix, input logic [7:0] val);
      frm[blk][pix*PW +: PW] = val;
      bgm[blk][pix*PW +: PW] = val;
   endtask

   task automatic check_cnts(input string tag, input int g, input int b, input int sg, input int sb);
      check_val({tag, " good_cnt"}, 64'(good_cnt), 64'(g));
      check_val({tag, " bad_cnt"}, 64'(bad_cnt), 64'(b));
      check_val({tag, " sat good_cnt"}, 64'(s_good_cnt), 64'(sg));
      check_val({tag, " sat bad_cnt"}, 64'(s_bad_cnt), 64'(sb));
   endtask

   // Entered on a negedge while idle; returns on the negedge of cycle 12
   // (first idle cycle), so a following call starts back-to-back.
   task automatic run_frame(input int mid_start, input int clr_at);
      for (int b = 0; b < NB; b++)
         msk[b] = 32'hDEAD_BEEF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         check_val("busy", 64'(busy), 64'(c <= 11));
         check_val("frame_done", 64'(frame_done), 64'(c == 11));
         check_val("wr_en", 64'(wr_en), 64'(c >= 3 && c <= 10));
         check_val("rd_addr", 64'(rd_addr), (c < NB) ? 64'(c) : 64'd0);
         if (wr_en) begin
            check_val("wr_addr", 64'(wr_addr), 64'(c - 3));
            msk[wr_addr] = wr_data;
         end
         start   = (c == mid_start);
         clr_cnt = (c == clr_at);
         if (c < 12)
            @(negedge clk);
      end
      start   = 1'b0;
      clr_cnt = 1'b0;
      for (int b = 0; b < NB; b++)
         check_val($sformatf("mask blk%0d", b), 64'(msk[b]), 64'(exp_msk[b]));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val("idle busy", 64'(busy), 64'd0);
         check_val("idle frame_done", 64'(frame_done), 64'd0);
         check_val("idle wr_en", 64'(wr_en), 64'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, " busy"}, 64'(busy), 64'd0);
      check_val({tag, " frame_done"}, 64'(frame_done), 64'd0);
      check_val({tag, " wr_en"}, 64'(wr_en), 64'd0);
      check_val({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
      check_val({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
      check_val({tag, " wr_data"}, 64'(wr_data), 64'd0);
      check_val({tag, " sat busy"}, 64'(s_busy), 64'd0);
      check_val({tag, " sat wr_en"}, 64'(s_wr_en), 64'd0);
      check_cnts(tag, 0, 0, 0, 0);
   endtask

   task automatic good_frame(input int blk);
      clear_mem();
      put_px(blk, 1, GOOD);
      run_frame(-1, -1);
   endtask

   task automatic clean_frame();
      clear_mem();
      run_frame(-1, -1);
   endtask

   initial begin
      clear_mem();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle_cycles(2);

      // Mask: only block 2 pixel 0 differs by 6.
      clear_mem();
      frm[2][7:0] = 8'd20;
      bgm[2][7:0] = 8'd14;
      exp_msk[2]  = 32'h0000_00FF;
      run_frame(-1, -1);
      check_cnts("mask1", 0, 0, 0, 0);

      // Mask edges: diff 5 is background, negative diff of 6 and 200 are
      // foreground, a fully differing block is all ones.
      clear_mem();
      frm[2][7:0]   = 8'd19;  bgm[2][7:0]   = 8'd14;
      frm[5][31:24] = 8'd10;  bgm[5][31:24] = 8'd16;
      frm[6][15:8]  = 8'd0;   bgm[6][15:8]  = 8'd200;
      frm[7]        = 32'hFFFF_FFFF;
      exp_msk[5]    = 32'hFF00_0000;
      exp_msk[6]    = 32'h0000_FF00;
      exp_msk[7]    = 32'hFFFF_FFFF;
      run_frame(-1, -1);
      check_cnts("mask2", 0, 0, 0, 0);

      // Single droplet across three frames, then clean, then a bad one.
      good_frame(3);
      check_cnts("drop f1", 1, 0, 1, 0);
      good_frame(3);
      good_frame(3);
      check_cnts("drop f3", 1, 0, 1, 0);
      clean_frame();
      clear_mem();
      put_px(4, 2, BAD);
      run_frame(-1, -1);
      check_cnts("drop f5", 1, 1, 1, 1);

      // Both codes in one window block: bad wins.
      clean_frame();
      clear_mem();
      put_px(3, 0, GOOD);
      put_px(3, 3, BAD);
      run_frame(-1, -1);
      check_cnts("priority", 1, 2, 1, 2);
      clean_frame();
      good_frame(2);
      check_cnts("below win", 1, 2, 1, 2);
      good_frame(5);
      check_cnts("above win", 1, 2, 1, 2);

      // Saturation of the 2-bit instance.
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      check_cnts("idle clr", 0, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
         good_frame(3);
         clean_frame();
         if (p == 2)
            check_cnts("sat 3", 3, 0, 3, 0);
      end
      check_cnts("sat hold", 4, 0, 3, 0);

      // Clear in the frame_done cycle of a counting frame, then the same
      // droplet again counts because the history was cleared too.
      clear_mem();
      put_px(3, 1, GOOD);
      run_frame(-1, 11);
      check_cnts("clr at done", 0, 0, 0, 0);
      good_frame(3);
      check_cnts("after clr", 1, 0, 1, 0);

      // Mid-frame start is dropped: exactly one frame_done, then idle.
      clear_mem();
      run_frame(5, -1);
      idle_cycles(4);
      check_cnts("mid start", 1, 0, 1, 0);

      // Back-to-back frames (run_frame returns in the first idle cycle).
      good_frame(4);
      clean_frame();
      check_cnts("b2b", 2, 0, 2, 0);

      // Reset in cycle 4 of a scan.
      clear_mem();
      put_px(3, 0, GOOD);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("rst wr_en", 64'(wr_en), 64'd0);
      end
      rst_n = 1'b1;
      idle_cycles(3);
      clean_frame();
      check_cnts("post reset", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
